// File: rtl/tap_loader_if.sv
// Signal bundle between the HPS download port, the TAP loader and the RAM arbiter.
// ioctl_wr is a one-cycle strobe, honoured only while ioctl_wait is low; a RAM write happens in any cycle with mem_req & mem_gnt.
interface tap_loader_if;
    logic       ioctl_download;
    logic [7:0] ioctl_index;
    logic       ioctl_wr;
    logic [7:0] ioctl_data;
    logic       ioctl_wait;
    logic       mem_req;
    logic       mem_gnt;
    logic [15:0] mem_addr;
    logic [7:0] mem_dout;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_data, mem_gnt,
        input  ioctl_wait, mem_req, mem_addr, mem_dout
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_data, mem_gnt,
        output ioctl_wait, mem_req, mem_addr, mem_dout
    );
endinterface

// File: rtl/tap_loader.sv
// KC TAP image loader: parses the file header and info block, then streams the
// payload bytes into RAM through a request/grant port, stalling the HPS per byte.
module tap_loader #(
    parameter logic [7:0] TAP_INDEX = 8'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    tap_loader_if.slave bus,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        exec_valid,
    output logic [15:0] exec_addr,
    output logic [3:0]  dbg_state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HDR    = 4'd1,
        S_BLKNUM = 4'd2,
        S_INFO   = 4'd3,
        S_DATA   = 4'd4,
        S_WRITE  = 4'd5,
        S_SKIP   = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_e;

    state_e      state_q, state_d;
    logic        dl_q, dl_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] cur_q, cur_d;
    logic [15:0] load_q, load_d;
    logic [15:0] end_q, end_d;
    logic [15:0] exe_q, exe_d;
    logic [7:0]  args_q, args_d;
    logic        info_done_q, info_done_d;
    logic        pend_q, pend_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;
    logic        exec_valid_q, exec_valid_d;
    logic [15:0] exec_addr_q, exec_addr_d;

    logic qual, start, acc;

    assign qual  = bus.ioctl_download && (bus.ioctl_index == TAP_INDEX);
    assign start = qual && !dl_q;
    assign acc   = bus.ioctl_wr && qual;

    always_comb begin
        state_d      = state_q;
        dl_d         = qual;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        load_d       = load_q;
        end_d        = end_q;
        exe_d        = exe_q;
        args_d       = args_q;
        info_done_d  = info_done_q;
        pend_d       = pend_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        busy_d       = busy_q;
        error_d      = error_q;
        exec_valid_d = exec_valid_q;
        exec_addr_d  = exec_addr_q;

        if (start && state_q != S_WRITE) begin
            // A byte may arrive in the same cycle the window opens; treat it as header byte 0.
            cnt_d = 8'd0; cur_d = 16'd0; load_d = 16'd0; end_d = 16'd0; exe_d = 16'd0;
            args_d = 8'd0; info_done_d = 1'b0; pend_d = 1'b0; busy_d = 1'b0;
            error_d = 1'b0; exec_valid_d = 1'b0; exec_addr_d = 16'd0;
            state_d = S_HDR;
            if (acc) begin
                busy_d = 1'b1;
                if (bus.ioctl_data != 8'hC3) state_d = S_ERR;
                else cnt_d = 8'd1;
            end
        end else begin
            case (state_q)
                S_HDR: begin
                    if (!qual) state_d = S_ERR;
                    else if (acc) begin
                        busy_d = 1'b1;
                        if (cnt_q == 8'd0 && bus.ioctl_data != 8'hC3) state_d = S_ERR;
                        else if (cnt_q == 8'd15) begin
                            cnt_d   = 8'd0;
                            state_d = S_BLKNUM;
                        end else cnt_d = cnt_q + 8'd1;
                    end
                end
                S_BLKNUM: begin
                    if (!qual) state_d = info_done_q ? S_DONE : S_ERR;
                    else if (acc) state_d = info_done_q ? S_DATA : S_INFO;
                end
                S_INFO: begin
                    if (!qual) state_d = S_ERR;
                    else if (acc) begin
                        case (cnt_q)
                            8'd16: args_d        = bus.ioctl_data;
                            8'd17: load_d[7:0]   = bus.ioctl_data;
                            8'd18: load_d[15:8]  = bus.ioctl_data;
                            8'd19: end_d[7:0]    = bus.ioctl_data;
                            8'd20: end_d[15:8]   = bus.ioctl_data;
                            8'd21: exe_d[7:0]    = bus.ioctl_data;
                            8'd22: exe_d[15:8]   = bus.ioctl_data;
                            default: ;
                        endcase
                        if (cnt_q == 8'd127) begin
                            cnt_d = 8'd0;
                            if (args_q < 8'd2 || end_q < load_q) state_d = S_ERR;
                            else begin
                                info_done_d = 1'b1;
                                cur_d       = load_q;
                                state_d     = S_BLKNUM;
                                if (args_q >= 8'd3) begin
                                    exec_valid_d = 1'b1;
                                    exec_addr_d  = exe_q;
                                end
                            end
                        end else cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DATA: begin
                    if (!qual) state_d = S_DONE;
                    else if (acc) begin
                        cnt_d = (cnt_q == 8'd127) ? 8'd0 : cnt_q + 8'd1;
                        // end is exclusive and checked before every write, so cur_q can never wrap.
                        if (cur_q < end_q) begin
                            addr_d  = cur_q;
                            dout_d  = bus.ioctl_data;
                            state_d = S_WRITE;
                        end else if (cnt_q == 8'd127) state_d = S_BLKNUM;
                    end
                end
                S_WRITE: begin
                    if (start) pend_d = 1'b1;
                    if (bus.mem_gnt) begin
                        cur_d  = cur_q + 16'd1;
                        pend_d = 1'b0;
                        if (pend_q || start) begin
                            cnt_d = 8'd0; cur_d = 16'd0; load_d = 16'd0; end_d = 16'd0; exe_d = 16'd0;
                            args_d = 8'd0; info_done_d = 1'b0; busy_d = 1'b0;
                            error_d = 1'b0; exec_valid_d = 1'b0; exec_addr_d = 16'd0;
                            state_d = S_HDR;
                        end else if (!qual) state_d = S_DONE;
                        else state_d = (cnt_q == 8'd0) ? S_BLKNUM : S_DATA;
                    end
                end
                S_ERR:   state_d = qual ? S_SKIP : S_IDLE;
                S_SKIP:  if (!qual) state_d = S_IDLE;
                S_DONE:  state_d = S_IDLE;
                default: ;
            endcase
        end

        if (state_d == S_ERR) error_d = 1'b1;
        if (state_d == S_ERR || state_d == S_DONE || state_d == S_IDLE) busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            // Assume a window may already be open so a reset mid-download waits for a fresh start.
            dl_q         <= 1'b1;
            cnt_q        <= 8'd0;
            cur_q        <= 16'd0;
            load_q       <= 16'd0;
            end_q        <= 16'd0;
            exe_q        <= 16'd0;
            args_q       <= 8'd0;
            info_done_q  <= 1'b0;
            pend_q       <= 1'b0;
            addr_q       <= 16'd0;
            dout_q       <= 8'd0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            exec_valid_q <= 1'b0;
            exec_addr_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            dl_q         <= dl_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            load_q       <= load_d;
            end_q        <= end_d;
            exe_q        <= exe_d;
            args_q       <= args_d;
            info_done_q  <= info_done_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            exec_valid_q <= exec_valid_d;
            exec_addr_q  <= exec_addr_d;
        end
    end

    assign bus.ioctl_wait = (state_q == S_WRITE);
    assign bus.mem_req    = (state_q == S_WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_dout   = dout_q;
    assign busy           = busy_q;
    assign done           = (state_q == S_DONE);
    assign error          = error_q;
    assign exec_valid     = exec_valid_q;
    assign exec_addr      = exec_addr_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_tap_loader.sv
// Bench for tap_loader: images built from the file format, expected RAM writes
// derived from the format rules and compared against the grant-side write monitor.
module tb_tap_loader;
    localparam logic [7:0] TAP_INDEX = 8'd1;
    localparam logic [3:0] ST_IDLE   = 4'd0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy, done, error, exec_valid;
    logic [15:0] exec_addr;
    logic [3:0]  dbg_state;

    tap_loader_if bus_if();

    tap_loader #(.TAP_INDEX(TAP_INDEX)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_if.slave),
        .busy(busy), .done(done), .error(error),
        .exec_valid(exec_valid), .exec_addr(exec_addr), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  img_q[$];
    int          lens_q[$];
    int done_cnt = 0, req_total = 0, wr_cnt = 0;
    int force_lat = -1, cur_lat = 0, lat_cnt = 0, req_len = 0;
    logic        in_req = 1'b0;
    logic [15:0] req_addr = 16'd0, last_wr_addr = 16'd0;
    logic [7:0]  req_data = 8'd0;
    logic        exp_err, exp_ev;
    int          exp_done;
    logic [15:0] exp_ea;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Grant driver first, then the monitor, so a grant raised here is seen with its request.
    always @(negedge clk) begin
        if (bus_if.mem_req && !bus_if.mem_gnt) begin
            if (lat_cnt >= cur_lat) bus_if.mem_gnt = 1'b1;
            else lat_cnt++;
        end else begin
            bus_if.mem_gnt = 1'b0;
            lat_cnt = 0;
            cur_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        end
        chk("wait_eq_req", {31'd0, bus_if.ioctl_wait}, {31'd0, bus_if.mem_req});
        if (done) done_cnt++;
        if (bus_if.mem_req) begin
            req_total++;
            if (!in_req) begin
                in_req = 1'b1; req_len = 1;
                req_addr = bus_if.mem_addr; req_data = bus_if.mem_dout;
            end else begin
                req_len++;
                chk("addr_stable", {16'd0, bus_if.mem_addr}, {16'd0, req_addr});
                chk("data_stable", {24'd0, bus_if.mem_dout}, {24'd0, req_data});
            end
            if (bus_if.mem_gnt) begin
                wr_cnt++;
                last_wr_addr = bus_if.mem_addr;
                chk("write_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0)
                    chk("write_addr_data", {8'd0, bus_if.mem_addr, bus_if.mem_dout}, {8'd0, exp_q.pop_front()});
            end
        end else if (in_req) begin
            in_req = 1'b0;
            lens_q.push_back(req_len);
        end
    end

    task automatic build(input logic [15:0] load, input logic [15:0] endad, input logic [7:0] args,
                         input logic [15:0] exe, input int ndata, input logic [7:0] hdr0, input bit seq);
        img_q.delete();
        img_q.push_back(hdr0);
        repeat (15) img_q.push_back(8'($urandom));
        img_q.push_back(8'h01);
        for (int k = 0; k < 128; k++) begin
            logic [7:0] v;
            v = 8'($urandom);
            case (k)
                16: v = args;
                17: v = load[7:0];
                18: v = load[15:8];
                19: v = endad[7:0];
                20: v = endad[15:8];
                21: v = exe[7:0];
                22: v = exe[15:8];
                default: ;
            endcase
            img_q.push_back(v);
        end
        for (int i = 0; i < ndata; i++) begin
            if (i % 128 == 0) img_q.push_back(8'(2 + i / 128));
            img_q.push_back(seq ? 8'(8'hAA + i * 17) : 8'($urandom));
        end
    endtask

    // Reference: header(16) + info record(129) must be complete and sane; every later
    // non-block-number byte k of the payload lands at load+k when below end.
    task automatic model();
        int n, args, load, endad, exe;
        n = img_q.size();
        exp_q.delete();
        exp_err = 1'b0; exp_done = 0; exp_ev = 1'b0; exp_ea = 16'd0;
        if (n < 145 || img_q[0] != 8'hC3) begin
            exp_err = 1'b1;
            return;
        end
        args  = int'(img_q[33]);
        load  = int'(img_q[34]) + 256 * int'(img_q[35]);
        endad = int'(img_q[36]) + 256 * int'(img_q[37]);
        exe   = int'(img_q[38]) + 256 * int'(img_q[39]);
        if (args < 2 || endad < load) begin
            exp_err = 1'b1;
            return;
        end
        exp_done = 1;
        exp_ev   = (args >= 3);
        exp_ea   = 16'(exe);
        for (int p = 145; p < n; p++) begin
            int off, a;
            off = p - 145;
            if (off % 129 != 0) begin
                a = load + (off / 129) * 128 + (off % 129) - 1;
                if (a < endad) exp_q.push_back({16'(a), img_q[p]});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int guard;
        guard = 0;
        while (bus_if.ioctl_wait && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("wait_timeout", {31'd0, bus_if.ioctl_wait}, 32'd0);
        bus_if.ioctl_wr = 1'b1;
        bus_if.ioctl_data = b;
        @(posedge clk); #1;
        bus_if.ioctl_wr = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    endtask

    task automatic run_image(input string tag, input int gap_max);
        int guard, done_base;
        model();
        done_base = done_cnt;
        bus_if.ioctl_index = TAP_INDEX;
        bus_if.ioctl_download = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < img_q.size(); i++) begin
            send_byte(img_q[i], gap_max);
            if (i == 1 && img_q[0] == 8'hC3) chk({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
        end
        bus_if.ioctl_download = 1'b0;
        guard = 0;
        while (dbg_state != ST_IDLE && guard < 100) begin @(posedge clk); #1; guard++; end
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, "_idle"}, {28'd0, dbg_state}, {28'd0, ST_IDLE});
        chk({tag, "_writes_left"}, exp_q.size(), 32'd0);
        chk({tag, "_done_cnt"}, done_cnt - done_base, exp_done);
        chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        chk({tag, "_exec_valid"}, {31'd0, exec_valid}, {31'd0, exp_ev});
        if (exp_ev) chk({tag, "_exec_addr"}, {16'd0, exec_addr}, {16'd0, exp_ea});
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_req_end"}, {31'd0, bus_if.mem_req}, 32'd0);
    endtask

    initial begin
        int base, wbase, lbase;
        #800000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, wbase, lbase;
        bus_if.ioctl_download = 1'b0;
        bus_if.ioctl_index = 8'd0;
        bus_if.ioctl_wr = 1'b0;
        bus_if.ioctl_data = 8'd0;
        repeat (3) begin @(posedge clk); #1; end

        // Reset state
        chk("rst_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
        chk("rst_outputs", {23'd0, bus_if.ioctl_wait, bus_if.mem_req, busy, done, error, exec_valid, 3'd0},
            32'd0);
        chk("rst_addr_data", {bus_if.mem_addr, bus_if.mem_dout, 8'd0}, 32'd0);
        chk("rst_exec_addr", {16'd0, exec_addr}, 32'd0);
        reset_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Strobes without a qualifying window are ignored
        base = req_total;
        bus_if.ioctl_index = TAP_INDEX;
        repeat (3) send_byte(8'hC3, 1);
        bus_if.ioctl_index = 8'h05;
        bus_if.ioctl_download = 1'b1;
        repeat (3) send_byte(8'hC3, 1);
        chk("ignore_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
        chk("ignore_busy", {31'd0, busy}, 32'd0);
        bus_if.ioctl_download = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("ignore_req", req_total - base, 32'd0);

        // Valid two-byte image with autostart
        wbase = wr_cnt;
        build(16'h0300, 16'h0302, 8'd3, 16'h0300, 128, 8'hC3, 1'b1);
        run_image("valid2", 2);
        chk("valid2_write_count", wr_cnt - wbase, 32'd2);

        // Bad header byte: never a request
        base = req_total;
        build(16'h0300, 16'h0400, 8'd3, 16'h0300, 200, 8'h00, 1'b0);
        run_image("badhdr", 1);
        chk("badhdr_no_req", req_total - base, 32'd0);

        // Grant withheld 10 cycles on the single write
        lbase = lens_q.size();
        force_lat = 10;
        build(16'h2000, 16'h2001, 8'd2, 16'h0000, 128, 8'hC3, 1'b0);
        run_image("slowgnt", 0);
        force_lat = -1;
        chk("slowgnt_req_count", lens_q.size() - lbase, 32'd1);
        chk("slowgnt_req_len", (lens_q.size() > lbase) ? lens_q[lbase] : -1, 32'd11);

        // Download ends inside the info block
        base = done_cnt;
        build(16'h0300, 16'h0400, 8'd3, 16'h0300, 0, 8'hC3, 1'b0);
        while (img_q.size() > 67) void'(img_q.pop_back());
        run_image("trunc_info", 1);
        chk("trunc_info_no_done", done_cnt - base, 32'd0);

        // Three full data records
        wbase = wr_cnt;
        build(16'h1000, 16'h1180, 8'd2, 16'h0000, 384, 8'hC3, 1'b0);
        run_image("three_rec", 0);
        chk("three_rec_writes", wr_cnt - wbase, 32'd384);
        chk("three_rec_last_addr", {16'd0, last_wr_addr}, 32'h117F);

        // Randomised images, including bad info and truncations
        for (int r = 0; r < 6; r++) begin
            logic [15:0] ld, ed;
            int nd;
            ld = 16'($urandom_range(0, 16'hE000));
            ed = ($urandom_range(0, 5) == 0) ? ld - 16'd1 : ld + 16'($urandom_range(0, 300));
            nd = $urandom_range(0, 400);
            build(ld, ed, 8'($urandom_range(0, 4)), 16'($urandom),
                  nd, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hC3, 1'b0);
            if ($urandom_range(0, 5) == 0) begin
                int keep;
                keep = $urandom_range(1, img_q.size());
                while (img_q.size() > keep) void'(img_q.pop_back());
            end
            run_image("random", 2);
        end

        // Reset while a write is waiting for its grant
        force_lat = 30;
        exp_q.delete();
        build(16'h4000, 16'h4100, 8'd2, 16'h0000, 40, 8'hC3, 1'b0);
        bus_if.ioctl_index = TAP_INDEX;
        bus_if.ioctl_download = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 147; i++) send_byte(img_q[i], 0);
        chk("rstw_in_write", {31'd0, bus_if.mem_req}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rstw_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
        chk("rstw_outputs", {25'd0, bus_if.ioctl_wait, bus_if.mem_req, busy, done, error, exec_valid, 1'b0},
            32'd0);
        chk("rstw_addr_data", {bus_if.mem_addr, bus_if.mem_dout, 8'd0}, 32'd0);
        reset_n = 1'b1;
        force_lat = -1;
        @(posedge clk); #1;
        base = req_total;
        for (int i = 147; i < 157; i++) send_byte(img_q[i], 1);
        chk("rstw_no_req", req_total - base, 32'd0);
        chk("rstw_stay_idle", {28'd0, dbg_state}, {28'd0, ST_IDLE});
        bus_if.ioctl_download = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Normal operation resumes after the reset
        build(16'h5000, 16'h5010, 8'd3, 16'h5004, 100, 8'hC3, 1'b0);
        run_image("after_rst", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tap_loader.md
TAP_LOADER -- requirements
Module: tap_loader

Interface
REQ-001 Parameter TAP_INDEX, default 8'd1: ioctl_index value that selects a KC TAP download.
REQ-002 clk  in  1  system clock; all logic rising-edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 ioctl_download  in  1  download window active.
REQ-005 ioctl_index  in  8  download type.
REQ-006 ioctl_wr  in  1  one-cycle strobe, ioctl_data valid.
REQ-007 ioctl_data  in  8  stream byte.
REQ-008 ioctl_wait  out  1  stall to HPS; no new ioctl_wr while high.
REQ-009 mem_req  out  1  RAM write request to CPU/RAM arbiter.
REQ-010 mem_gnt  in  1  arbiter grant; write occurs in the cycle mem_req and mem_gnt are both high.
REQ-011 mem_addr  out  16  write address.
REQ-012 mem_dout  out  8  write data.
REQ-013 busy  out  1  high from first accepted byte until DONE/ERR.
REQ-014 done  out  1  one-cycle pulse on successful completion.
REQ-015 error  out  1  sticky fault flag.
REQ-016 exec_valid  out  1  image carries an autostart address.
REQ-017 exec_addr  out  16  autostart address.

Function
REQ-018 Bytes are accepted only on ioctl_wr & ioctl_download & (ioctl_index==TAP_INDEX); all other strobes are ignored.
REQ-019 Stream layout: 16-byte file header, then 129-byte records (1 block-number byte + 128 data bytes); the first record is the info block.
REQ-020 States: IDLE, HDR, BLKNUM, INFO, DATA, WRITE, SKIP, DONE, ERR.
REQ-021 IDLE->HDR on rising edge of a qualifying download; clears error, exec_valid, and all counters.
REQ-022 HDR: byte 0 must equal 8'hC3, else ERR; bytes 1-15 ignored; after byte 15 -> BLKNUM.
REQ-023 BLKNUM: block-number byte discarded; -> INFO for the first record, else DATA.
REQ-024 INFO: data byte 16 = arg count, bytes 17/18 = load address (LE), 19/20 = end address (LE, exclusive), 21/22 = exec address (LE); all other bytes ignored; after byte 127 -> BLKNUM.
REQ-025 Info check at end of INFO: arg count < 2 or end < load -> ERR; arg count >= 3 -> exec_valid=1, exec_addr latched.
REQ-026 DATA: each byte with cur_addr < end -> WRITE with mem_addr=cur_addr, mem_dout=byte, mem_req=1, ioctl_wait=1, all asserted the cycle after the strobe.
REQ-027 Bytes with cur_addr >= end are discarded and not written; trailing padding is legal.
REQ-028 WRITE: mem_addr/mem_dout/mem_req held stable until mem_gnt=1; in the grant cycle the write occurs and cur_addr increments; next cycle mem_req=0, ioctl_wait=0, and the state returns to DATA, or to BLKNUM after data byte 127.
REQ-029 Per-record byte counter is 8-bit and wraps to 0 after 128 data bytes; cur_addr is 16-bit and never wraps, because end is compared before each write.
REQ-030 Falling ioctl_download in BLKNUM/DATA (info accepted) -> DONE; in HDR/INFO -> ERR; in WRITE the pending write completes first, then DONE.
REQ-031 DONE: done pulses once -> IDLE; busy=0.
REQ-032 ERR: error=1, mem_req=0, ioctl_wait=0, remaining bytes consumed (SKIP) until download falls -> IDLE; error stays set until the next download start.
REQ-033 A new qualifying download start while not IDLE re-enters HDR with full clear, except in WRITE, where the pending grant is honoured first.
REQ-034 ioctl_wait is never high for more than the WRITE wait plus one cycle per byte; it is low in all states except WRITE.

Reset
REQ-035 reset_n=0 at a clock edge: state=IDLE; ioctl_wait, mem_req, busy, done, error, exec_valid = 0; mem_addr, mem_dout, exec_addr = 0.
REQ-036 Reset mid-WRITE abandons the write without a grant cycle; no further mem_req until a new download.

Verification
REQ-037 Valid image: load=0x0300, end=0x0302, args=3, exec=0x0300, data AA,BB,... -> exactly two writes (0x0300=AA, 0x0301=BB), done pulse, exec_valid=1, exec_addr=0x0300, error=0.
REQ-038 Header byte 0 = 0x00 -> error=1, no mem_req for the whole download, busy falls after download ends.
REQ-039 Grant held low 10 cycles on the first data byte -> mem_req and ioctl_wait high for exactly 10+1 cycles, addr/data stable, single write.
REQ-040 Download ends after 50 info bytes -> error=1, done never pulses.
REQ-041 Image spanning 3 data records, load=0x1000, end=0x1180 -> 384 bytes received, 384 writes ending at 0x117F, block-number bytes never written.
REQ-042 reset_n low during WRITE -> next cycle all outputs 0, state IDLE.
